// File: rtl/ldpc_encode_row_sequencer_if.sv
// Handshake and datapath-control bundle for the QC-LDPC encoder row sequencer.
// The master side is the sequencer itself. The slave side is the surrounding
// message source, G row store, accumulator and codeword sink.
interface ldpc_encode_row_sequencer_if #(
  parameter int SEL_W   = 6,
  parameter int SHIFT_W = 4
);
  // block-level handshake
  logic               start;
  logic               ready;
  logic               abort;
  // serial message input
  logic               msg_valid;
  logic               msg_ready;
  // row store / accumulator control
  logic [SEL_W-1:0]   sel;
  logic [SHIFT_W-1:0] shift;
  logic               acc_clear;
  logic               acc_en;
  logic               first;
  logic               last;
  // codeword output handshake
  logic               cw_valid;
  logic               cw_ready;

  modport master (
    input  start,
    output ready,
    input  abort,
    input  msg_valid,
    output msg_ready,
    output sel,
    output shift,
    output acc_clear,
    output acc_en,
    output first,
    output last,
    output cw_valid,
    input  cw_ready
  );

  modport slave (
    output start,
    input  ready,
    output abort,
    output msg_valid,
    input  msg_ready,
    input  sel,
    input  shift,
    input  acc_clear,
    input  acc_en,
    input  first,
    input  last,
    input  cw_valid,
    output cw_ready
  );
endinterface

// File: rtl/ldpc_encode_row_sequencer.sv
// QC-LDPC encoder row sequencer.
// It walks the generator-matrix block-rows one message bit at a time, with
// bit k = sel*CIRC_SIZE + shift. For each bit it issues the row select, the
// circulant shift and the accumulate strobes to the XOR-accumulate datapath.
// It then holds the finished codeword until the downstream sink takes it.
// Every output is registered except msg_ready and acc_en. Those two must
// react in the same cycle as msg_valid so that no beat is lost.
module ldpc_encode_row_sequencer #(
  parameter int NUM_ROWS  = 39,
  parameter int CIRC_SIZE = 16,
  parameter int SEL_W     = 6,
  parameter int SHIFT_W   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  ldpc_encode_row_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [SEL_W-1:0]   SEL_ZERO   = {SEL_W{1'b0}};
  localparam logic [SHIFT_W-1:0] SHIFT_ZERO = {SHIFT_W{1'b0}};
  localparam logic [SEL_W-1:0]   SEL_ONE    = {{(SEL_W-1){1'b0}}, 1'b1};
  localparam logic [SHIFT_W-1:0] SHIFT_ONE  = {{(SHIFT_W-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(NUM_ROWS - 1);
  localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(CIRC_SIZE - 1);

  // registered state, counters and outputs
  state_t             state_r;
  logic [SEL_W-1:0]   sel_r;
  logic [SHIFT_W-1:0] shift_r;
  logic               ready_r;
  logic               acc_clear_r;
  logic               first_r;
  logic               last_r;
  logic               cw_valid_r;

  // next-cycle values
  state_t             state_nxt_s;
  logic [SEL_W-1:0]   sel_nxt_s;
  logic [SHIFT_W-1:0] shift_nxt_s;
  logic               ready_nxt_s;
  logic               acc_clear_nxt_s;
  logic               first_nxt_s;
  logic               last_nxt_s;
  logic               cw_valid_nxt_s;

  // per-cycle decodes
  logic               run_s;
  logic               beat_s;
  logic               at_end_s;

  // A beat is a consumed message bit. Abort suppresses it, so the
  // accumulator is left untouched in the abort cycle.
  assign run_s    = (state_r == RUN);
  assign beat_s   = run_s & bus.msg_valid & ~bus.abort;
  assign at_end_s = (sel_r == SEL_LAST) & (shift_r == SHIFT_LAST);

  assign bus.ready     = ready_r;
  assign bus.msg_ready = run_s;
  assign bus.acc_en    = beat_s;
  assign bus.sel       = sel_r;
  assign bus.shift     = shift_r;
  assign bus.acc_clear = acc_clear_r;
  assign bus.first     = first_r;
  assign bus.last      = last_r;
  assign bus.cw_valid  = cw_valid_r;

  // State, counter and output registers; async reset forces IDLE immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      sel_r       <= SEL_ZERO;
      shift_r     <= SHIFT_ZERO;
      ready_r     <= 1'b1;
      acc_clear_r <= 1'b0;
      first_r     <= 1'b0;
      last_r      <= 1'b0;
      cw_valid_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      sel_r       <= sel_nxt_s;
      shift_r     <= shift_nxt_s;
      ready_r     <= ready_nxt_s;
      acc_clear_r <= acc_clear_nxt_s;
      first_r     <= first_nxt_s;
      last_r      <= last_nxt_s;
      cw_valid_r  <= cw_valid_nxt_s;
    end
  end

  // Next-state logic; abort beats every other request, including start in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.abort) begin
          state_nxt_s = IDLE;
        end else if (bus.start) begin
          state_nxt_s = CLEAR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CLEAR: begin
        if (bus.abort) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_nxt_s = IDLE;
        end else if (beat_s && at_end_s) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FLUSH: begin
        if (bus.abort) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      DONE: begin
        if (bus.abort || bus.cw_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Counter advance: shift counts within a block-row and sel counts block-rows.
  // Both are zero outside RUN, and the final beat wraps them back to zero.
  always_comb begin
    sel_nxt_s   = sel_r;
    shift_nxt_s = shift_r;
    if (bus.abort || !run_s) begin
      sel_nxt_s   = SEL_ZERO;
      shift_nxt_s = SHIFT_ZERO;
    end else if (beat_s) begin
      if (shift_r == SHIFT_LAST) begin
        shift_nxt_s = SHIFT_ZERO;
        if (sel_r == SEL_LAST) begin
          sel_nxt_s = SEL_ZERO;
        end else begin
          sel_nxt_s = sel_r + SEL_ONE;
        end
      end else begin
        shift_nxt_s = shift_r + SHIFT_ONE;
        sel_nxt_s   = sel_r;
      end
    end else begin
      sel_nxt_s   = sel_r;
      shift_nxt_s = shift_r;
    end
  end

  // Output decode from the next state, so the registered outputs track the state they describe.
  always_comb begin
    ready_nxt_s     = 1'b0;
    acc_clear_nxt_s = 1'b0;
    first_nxt_s     = 1'b0;
    last_nxt_s      = 1'b0;
    cw_valid_nxt_s  = 1'b0;
    case (state_nxt_s)
      IDLE: begin
        ready_nxt_s = 1'b1;
      end
      CLEAR: begin
        acc_clear_nxt_s = 1'b1;
      end
      RUN: begin
        first_nxt_s = (sel_nxt_s == SEL_ZERO) && (shift_nxt_s == SHIFT_ZERO);
        last_nxt_s  = (sel_nxt_s == SEL_LAST) && (shift_nxt_s == SHIFT_LAST);
      end
      FLUSH: begin
        ready_nxt_s = 1'b0;
      end
      DONE: begin
        cw_valid_nxt_s = 1'b1;
      end
      default: begin
        ready_nxt_s = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ldpc_encode_row_sequencer.sv
// Self-checking bench for ldpc_encode_row_sequencer.
// When a block is started, the expected beats (sel, shift, first, last) are
// pushed to a queue. A negedge monitor pops one entry per acc_en beat and
// compares it against the DUT outputs.
module tb_ldpc_encode_row_sequencer;
  localparam int NUM_ROWS  = 39;
  localparam int CIRC_SIZE = 16;
  localparam int BEATS     = NUM_ROWS * CIRC_SIZE;

  typedef struct {
    logic [5:0] sel;
    logic [3:0] shift;
    logic       first;
    logic       last;
  } beat_t;

  logic  clk;
  logic  rst;
  int    n_checks;
  int    n_errors;
  beat_t exp_q[$];

  ldpc_encode_row_sequencer_if #(.SEL_W(6), .SHIFT_W(4)) bus ();

  ldpc_encode_row_sequencer #(
    .NUM_ROWS(NUM_ROWS), .CIRC_SIZE(CIRC_SIZE), .SEL_W(6), .SHIFT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_beats(input int n);
    beat_t e;
    for (int k = 0; k < n; k++) begin
      e.sel   = 6'(k / CIRC_SIZE);
      e.shift = 4'(k % CIRC_SIZE);
      e.first = (k == 0);
      e.last  = (k == BEATS - 1);
      exp_q.push_back(e);
    end
  endtask

  // Scoreboard monitor: every acc_en beat must match the next expected beat.
  always @(negedge clk) begin
    if (!rst && bus.acc_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_beat", 32'd1, 32'd0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check_val("beat_sel", 32'(bus.sel), 32'(e.sel));
        check_val("beat_shift", 32'(bus.shift), 32'(e.shift));
        check_val("beat_first", 32'(bus.first), 32'(e.first));
        check_val("beat_last", 32'(bus.last), 32'(e.last));
      end
    end
  end

  // Start pulse from IDLE; returns in the CLEAR cycle.
  task automatic pulse_start();
    check_val("ready_before_start", 32'(bus.ready), 32'd1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_val("acc_clear", 32'(bus.acc_clear), 32'd1);
    check_val("clear_sel", 32'(bus.sel), 32'd0);
    check_val("clear_shift", 32'(bus.shift), 32'd0);
    check_val("clear_ready", 32'(bus.ready), 32'd0);
  endtask

  // Feed message bits from the CLEAR cycle until cw_valid, then check latency.
  task automatic run_to_done(input bit toggle, input bit inject);
    int cycles;
    int idle;
    cycles = 0;
    idle   = 0;
    while (bus.cw_valid !== 1'b1 && cycles < 3000) begin
      bus.msg_valid = toggle ? (cycles % 2 == 0) : 1'b1;
      bus.start     = inject && (cycles == 100);
      bus.cw_ready  = inject && (cycles == 100);
      if (inject && cycles == 100) check_val("ready_in_run", 32'(bus.ready), 32'd0);
      @(negedge clk);
      if (bus.msg_ready && !bus.msg_valid) idle++;
      @(posedge clk); #1;
      cycles++;
    end
    bus.msg_valid = 1'b0;
    bus.start     = 1'b0;
    bus.cw_ready  = 1'b0;
    check_val("cw_valid_rise", 32'(bus.cw_valid), 32'd1);
    check_val("cw_latency", 32'(cycles), 32'(BEATS + 2 + idle));
    check_val("beats_remaining", 32'(exp_q.size()), 32'd0);
    check_val("done_ready", 32'(bus.ready), 32'd0);
  endtask

  task automatic finish_done(input int hold);
    for (int i = 0; i < hold; i++) begin
      bus.cw_ready = 1'b0;
      @(posedge clk); #1;
      check_val("hold_cw_valid", 32'(bus.cw_valid), 32'd1);
      check_val("hold_ready", 32'(bus.ready), 32'd0);
    end
    bus.cw_ready = 1'b1;
    @(posedge clk); #1;
    bus.cw_ready = 1'b0;
    check_val("after_take_ready", 32'(bus.ready), 32'd1);
    check_val("after_take_cw_valid", 32'(bus.cw_valid), 32'd0);
  endtask

  initial begin
    int cycles;
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.msg_valid = 1'b0;
    bus.cw_ready  = 1'b0;
    #12;
    check_val("rst_ready", 32'(bus.ready), 32'd1);
    check_val("rst_acc_clear", 32'(bus.acc_clear), 32'd0);
    check_val("rst_cw_valid", 32'(bus.cw_valid), 32'd0);
    check_val("rst_sel", 32'(bus.sel), 32'd0);
    check_val("rst_shift", 32'(bus.shift), 32'd0);
    check_val("rst_msg_ready", 32'(bus.msg_ready), 32'd0);
    check_val("rst_first_last", 32'({bus.first, bus.last}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // abort and start together in IDLE: abort wins
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check_val("abort_start_ready", 32'(bus.ready), 32'd1);
    check_val("abort_start_clear", 32'(bus.acc_clear), 32'd0);

    // 1: full block with msg_valid held high
    push_beats(BEATS);
    pulse_start();
    run_to_done(1'b0, 1'b0);
    finish_done(0);

    // 2 + 3: toggled msg_valid, then cw_ready held low for 10 cycles
    push_beats(BEATS);
    pulse_start();
    run_to_done(1'b1, 1'b0);
    finish_done(10);

    // 6: start and cw_ready pulsed during RUN, then cw_ready+start together in DONE
    push_beats(BEATS);
    pulse_start();
    run_to_done(1'b0, 1'b1);
    push_beats(BEATS);
    bus.start    = 1'b1;
    bus.cw_ready = 1'b1;
    @(posedge clk); #1;
    bus.cw_ready = 1'b0;
    check_val("done_start_ready", 32'(bus.ready), 32'd1);
    check_val("done_start_no_clear", 32'(bus.acc_clear), 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_val("next_start_clear", 32'(bus.acc_clear), 32'd1);
    run_to_done(1'b0, 1'b0);
    finish_done(0);

    // 4: abort at sel=5, shift=7
    push_beats(5 * CIRC_SIZE + 7);
    pulse_start();
    cycles = 0;
    bus.msg_valid = 1'b1;
    while (cycles < 5 * CIRC_SIZE + 7 + 1) begin
      @(posedge clk); #1;
      cycles++;
    end
    check_val("abort_pos_sel", 32'(bus.sel), 32'd5);
    check_val("abort_pos_shift", 32'(bus.shift), 32'd7);
    bus.abort = 1'b1;
    @(negedge clk);
    check_val("abort_no_acc_en", 32'(bus.acc_en), 32'd0);
    @(posedge clk); #1;
    bus.abort     = 1'b0;
    bus.msg_valid = 1'b0;
    check_val("abort_ready", 32'(bus.ready), 32'd1);
    check_val("abort_sel", 32'(bus.sel), 32'd0);
    check_val("abort_shift", 32'(bus.shift), 32'd0);
    check_val("abort_msg_ready", 32'(bus.msg_ready), 32'd0);
    check_val("abort_beats_left", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_val("abort_cw_valid", 32'(bus.cw_valid), 32'd0);
    end

    // 5: rst mid-RUN between edges, then a full block
    push_beats(BEATS);
    pulse_start();
    bus.msg_valid = 1'b1;
    repeat (40) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_val("midrst_ready", 32'(bus.ready), 32'd1);
    check_val("midrst_sel", 32'(bus.sel), 32'd0);
    check_val("midrst_shift", 32'(bus.shift), 32'd0);
    check_val("midrst_msg_ready", 32'(bus.msg_ready), 32'd0);
    check_val("midrst_acc_en", 32'(bus.acc_en), 32'd0);
    exp_q.delete();
    bus.msg_valid = 1'b0;
    #3;
    rst = 1'b0;
    @(posedge clk); #1;
    push_beats(BEATS);
    pulse_start();
    run_to_done(1'b0, 1'b0);
    finish_done(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound in case the DUT never progresses.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end
endmodule
